mlp_sequencer: RTL and testbench

Parametrised layer sequencer for the MLP inference datapath. It replaces the fixed single-layer control unit and its hand-instantiated control delay buffers. It walks any number of fully-connected layers of configurable size. It generates neuron, weight and bias read addresses, and emits MAC/write/done controls delayed by a configurable pipeline depth so that they line up with memory and MAC latency. Between layers it inserts drain cycles so a layer never reads neurons that have not yet been written.

---
 rtl/mlp_sequencer.sv | 239 +++++++++++++++++++++++
 tb/tb_mlp_sequencer.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/mlp_sequencer.sv
// Layer sequencer for the MLP inference datapath: walks fully-connected layers, drives
// neuron/weight/bias read addresses and emits MAC/write/done controls delayed by PIPE_DEPTH.
module mlp_sequencer #(
  parameter int NUM_LAYERS = 3,
  parameter logic [(NUM_LAYERS+1)*12-1:0] LAYER_SIZES = {12'd10, 12'd32, 12'd64, 12'd784},
  parameter int PIPE_DEPTH = 2,
  parameter int N_ADDR_W = 12,
  parameter int W_ADDR_W = 16,
  parameter int B_ADDR_W = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                stall,
  output logic [N_ADDR_W-1:0] in_neuron_addr,
  output logic [W_ADDR_W-1:0] weight_addr,
  output logic [B_ADDR_W-1:0] bias_addr,
  output logic                acc_clear_o,
  output logic                acc_en_o,
  output logic                write_neuron_o,
  output logic [N_ADDR_W-1:0] out_neuron_addr_o,
  output logic                last_layer_o,
  output logic                done,
  output logic                busy
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_MAC   = 3'd1;
  localparam logic [2:0] ST_WRITE = 3'd2;
  localparam logic [2:0] ST_DRAIN = 3'd3;
  localparam logic [2:0] ST_FLUSH = 3'd4;

  localparam int LW = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;
  localparam int CW = 4;
  localparam int PW = 5 + N_ADDR_W;
  localparam int BIT_CLR  = 0;
  localparam int BIT_EN   = 1;
  localparam int BIT_WR   = 2;
  localparam int BIT_LAST = 3;
  localparam int BIT_DONE = 4;

  function automatic logic [11:0] size_at(input int k);
    return LAYER_SIZES[k*12 +: 12];
  endfunction

  function automatic longint sum_neurons();
    longint s = 0;
    for (int k = 0; k <= NUM_LAYERS; k++) s += longint'(size_at(k));
    return s;
  endfunction

  function automatic longint sum_weights();
    longint s = 0;
    for (int k = 0; k < NUM_LAYERS; k++) s += longint'(size_at(k)) * longint'(size_at(k + 1));
    return s;
  endfunction

  function automatic longint sum_biases();
    longint s = 0;
    for (int k = 1; k <= NUM_LAYERS; k++) s += longint'(size_at(k));
    return s;
  endfunction

  function automatic longint min_size();
    longint m = 4096;
    for (int k = 0; k <= NUM_LAYERS; k++) if (longint'(size_at(k)) < m) m = longint'(size_at(k));
    return m;
  endfunction

  if (NUM_LAYERS < 1) begin : g_bad_layers
    $error("mlp_sequencer: NUM_LAYERS must be at least 1");
  end
  if (PIPE_DEPTH < 0 || PIPE_DEPTH > 8) begin : g_bad_depth
    $error("mlp_sequencer: PIPE_DEPTH must be 0..8");
  end
  if (min_size() < 1) begin : g_bad_size
    $error("mlp_sequencer: every layer size must be at least 1");
  end
  if (sum_neurons() > (longint'(1) <<< N_ADDR_W)) begin : g_bad_naddr
    $error("mlp_sequencer: neuron memory does not fit N_ADDR_W");
  end
  if (sum_weights() > (longint'(1) <<< W_ADDR_W)) begin : g_bad_waddr
    $error("mlp_sequencer: weight memory does not fit W_ADDR_W");
  end
  if (sum_biases() > (longint'(1) <<< B_ADDR_W)) begin : g_bad_baddr
    $error("mlp_sequencer: bias memory does not fit B_ADDR_W");
  end

  logic [2:0]          state_q, state_d;
  logic [LW-1:0]       layer_q, layer_d;
  logic [11:0]         i_q, i_d, j_q, j_d;
  logic [N_ADDR_W-1:0] in_base_q, in_base_d, out_base_q, out_base_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [W_ADDR_W-1:0] w_cnt_q, w_cnt_d, w_addr_q, w_addr_d;
  logic [B_ADDR_W-1:0] b_cnt_q, b_cnt_d, b_addr_q, b_addr_d;
  logic [N_ADDR_W-1:0] nrn_addr_q, nrn_addr_d;
  logic [PW-1:0]       issue_d;
  logic [PW-1:0]       pipe_q [PIPE_DEPTH+1];
  logic [PW-1:0]       pipe_out;
  logic [11:0]         s_in, s_out;
  logic                last_layer, mac_step;

  assign s_in       = size_at(int'(layer_q));
  assign s_out      = size_at(int'(layer_q) + 1);
  assign last_layer = (layer_q == LW'(NUM_LAYERS - 1));

  always_comb begin
    state_d    = state_q;
    layer_d    = layer_q;
    i_d        = i_q;
    j_d        = j_q;
    in_base_d  = in_base_q;
    out_base_d = out_base_q;
    cnt_d      = cnt_q;
    w_cnt_d    = w_cnt_q;
    b_cnt_d    = b_cnt_q;
    nrn_addr_d = nrn_addr_q;
    w_addr_d   = w_addr_q;
    b_addr_d   = b_addr_q;
    issue_d    = '0;
    mac_step   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          layer_d    = '0;
          i_d        = '0;
          j_d        = '0;
          in_base_d  = '0;
          out_base_d = N_ADDR_W'(size_at(0));
          w_cnt_d    = '0;
          b_cnt_d    = '0;
          mac_step   = 1'b1;
        end
      end
      ST_MAC: begin
        if (i_q == s_in - 12'd1) begin
          state_d                = ST_WRITE;
          b_cnt_d                = b_cnt_q + B_ADDR_W'(1);
          issue_d[BIT_WR]        = 1'b1;
          issue_d[BIT_LAST]      = last_layer;
          issue_d[BIT_DONE]      = last_layer && (j_q == s_out - 12'd1);
          issue_d[PW-1:5]        = out_base_q + N_ADDR_W'(j_q);
        end else begin
          i_d      = i_q + 12'd1;
          mac_step = 1'b1;
        end
      end
      ST_WRITE: begin
        if (j_q != s_out - 12'd1) begin
          j_d      = j_q + 12'd1;
          i_d      = '0;
          mac_step = 1'b1;
        end else if (!last_layer) begin
          state_d = ST_DRAIN;
          cnt_d   = '0;
        end else if (PIPE_DEPTH == 0) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_FLUSH;
          cnt_d   = '0;
        end
      end
      ST_DRAIN: begin
        // Hold off the next layer until the last write of this one has left the pipeline.
        if (cnt_q == CW'(PIPE_DEPTH)) begin
          layer_d    = layer_q + LW'(1);
          in_base_d  = out_base_q;
          out_base_d = out_base_q + N_ADDR_W'(s_out);
          i_d        = '0;
          j_d        = '0;
          mac_step   = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_FLUSH: begin
        if (cnt_q == CW'(PIPE_DEPTH - 1)) state_d = ST_IDLE;
        else cnt_d = cnt_q + CW'(1);
      end
      default: state_d = ST_IDLE;
    endcase
    // Every MAC issue consumes one weight and reads the current input neuron and bias.
    if (mac_step) begin
      state_d          = ST_MAC;
      nrn_addr_d       = in_base_d + N_ADDR_W'(i_d);
      w_addr_d         = w_cnt_d;
      w_cnt_d          = w_cnt_d + W_ADDR_W'(1);
      b_addr_d         = b_cnt_d;
      issue_d[BIT_EN]  = 1'b1;
      issue_d[BIT_CLR] = (i_d == 12'd0);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      layer_q    <= '0;
      i_q        <= '0;
      j_q        <= '0;
      in_base_q  <= '0;
      out_base_q <= '0;
      cnt_q      <= '0;
      w_cnt_q    <= '0;
      b_cnt_q    <= '0;
      nrn_addr_q <= '0;
      w_addr_q   <= '0;
      b_addr_q   <= '0;
      for (int d = 0; d <= PIPE_DEPTH; d++) pipe_q[d] <= '0;
    end else if (!stall) begin
      state_q    <= state_d;
      layer_q    <= layer_d;
      i_q        <= i_d;
      j_q        <= j_d;
      in_base_q  <= in_base_d;
      out_base_q <= out_base_d;
      cnt_q      <= cnt_d;
      w_cnt_q    <= w_cnt_d;
      b_cnt_q    <= b_cnt_d;
      nrn_addr_q <= nrn_addr_d;
      w_addr_q   <= w_addr_d;
      b_addr_q   <= b_addr_d;
      pipe_q[0]  <= issue_d;
      for (int d = 1; d <= PIPE_DEPTH; d++) pipe_q[d] <= pipe_q[d-1];
    end
  end

  assign pipe_out          = pipe_q[PIPE_DEPTH];
  assign in_neuron_addr    = nrn_addr_q;
  assign weight_addr       = w_addr_q;
  assign bias_addr         = b_addr_q;
  assign acc_clear_o       = pipe_out[BIT_CLR] & ~stall;
  assign acc_en_o          = pipe_out[BIT_EN] & ~stall;
  assign write_neuron_o    = pipe_out[BIT_WR] & ~stall;
  assign done              = pipe_out[BIT_DONE] & ~stall;
  assign last_layer_o      = pipe_out[BIT_LAST];
  assign out_neuron_addr_o = pipe_out[PW-1:5];
  assign busy              = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mlp_sequencer.sv
// Directed bench for mlp_sequencer with sizes {2,3,2}: PIPE_DEPTH=2 and PIPE_DEPTH=0 instances,
// covering nominal timing, stall, mid-run reset and start-while-busy.
module tb_mlp_sequencer;

  localparam logic [35:0] SIZES = {12'd2, 12'd3, 12'd2};

  // f = {start, acc_clear, acc_en, write, last_layer, done, busy}
  typedef struct {
    logic [6:0]  f;
    logic [11:0] oa;
    logic [11:0] nrn;
    logic [15:0] w;
    logic [7:0]  b;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_a, rst_z, start, stall_a;
  logic [11:0] nrn_a, oaddr_a, nrn_z, oaddr_z;
  logic [15:0] w_a, w_z;
  logic [7:0]  b_a, b_z;
  logic        clr_a, en_a, wr_a, last_a, done_a, busy_a;
  logic        clr_z, en_z, wr_z, last_z, done_z, busy_z;

  int n_cmp = 0;
  int n_bad = 0;
  int dones;
  vec_t tab_a[25];
  vec_t tab_z[25];
  logic [11:0] exp_q[$];

  always #5 clk = ~clk;

  mlp_sequencer #(.NUM_LAYERS(2), .LAYER_SIZES(SIZES), .PIPE_DEPTH(2)) u_dut (
    .clk(clk), .reset(rst_a), .start(start), .stall(stall_a),
    .in_neuron_addr(nrn_a), .weight_addr(w_a), .bias_addr(b_a),
    .acc_clear_o(clr_a), .acc_en_o(en_a), .write_neuron_o(wr_a),
    .out_neuron_addr_o(oaddr_a), .last_layer_o(last_a), .done(done_a), .busy(busy_a)
  );

  mlp_sequencer #(.NUM_LAYERS(2), .LAYER_SIZES(SIZES), .PIPE_DEPTH(0)) u_dut0 (
    .clk(clk), .reset(rst_z), .start(start), .stall(1'b0),
    .in_neuron_addr(nrn_z), .weight_addr(w_z), .bias_addr(b_z),
    .acc_clear_o(clr_z), .acc_en_o(en_z), .write_neuron_o(wr_z),
    .out_neuron_addr_o(oaddr_z), .last_layer_o(last_z), .done(done_z), .busy(busy_z)
  );

  function automatic vec_t mk(input logic [6:0] f, input int oa, input int n, input int w, input int b);
    vec_t v;
    v.f = f; v.oa = 12'(oa); v.nrn = 12'(n); v.w = 16'(w); v.b = 8'(b);
    return v;
  endfunction

  task automatic check(input string name, input int c, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, c, act, exp);
    end
  endtask

  task automatic check_a(input int c, input int r);
    check("pulses_a", c, 64'({clr_a, en_a, wr_a, last_a, done_a, busy_a}), 64'(tab_a[r].f[5:0]));
    if (tab_a[r].f[3]) check("oaddr_a", c, 64'(oaddr_a), 64'(tab_a[r].oa));
    check("rdaddr_a", c, 64'({nrn_a, w_a, b_a}), 64'({tab_a[r].nrn, tab_a[r].w, tab_a[r].b}));
  endtask

  task automatic check_quiet(input string name, input int c);
    check(name, c, 64'({clr_a, en_a, wr_a, last_a, done_a, busy_a, oaddr_a, nrn_a, w_a, b_a}), 64'd0);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic with_z);
    start = 1'b0; stall_a = 1'b0; rst_a = 1'b0; rst_z = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_quiet("reset_state", -1);
    next_cycle();
    rst_a = 1'b1; rst_z = with_z;
    next_cycle();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tab_a[0]  = mk(7'b1000000, 0, 0, 0, 0);   tab_a[1]  = mk(7'b0000001, 0, 0, 0, 0);
    tab_a[2]  = mk(7'b0000001, 0, 1, 1, 0);   tab_a[3]  = mk(7'b0110001, 0, 1, 1, 0);
    tab_a[4]  = mk(7'b0010001, 0, 0, 2, 1);   tab_a[5]  = mk(7'b0001001, 2, 1, 3, 1);
    tab_a[6]  = mk(7'b0110001, 0, 1, 3, 1);   tab_a[7]  = mk(7'b0010001, 0, 0, 4, 2);
    tab_a[8]  = mk(7'b0001001, 3, 1, 5, 2);   tab_a[9]  = mk(7'b0110001, 0, 1, 5, 2);
    tab_a[10] = mk(7'b1010001, 0, 1, 5, 2);   tab_a[11] = mk(7'b0001001, 4, 1, 5, 2);
    tab_a[12] = mk(7'b0000001, 0, 1, 5, 2);   tab_a[13] = mk(7'b0000001, 0, 2, 6, 3);
    tab_a[14] = mk(7'b0000001, 0, 3, 7, 3);   tab_a[15] = mk(7'b0110001, 0, 4, 8, 3);
    tab_a[16] = mk(7'b0010001, 0, 4, 8, 3);   tab_a[17] = mk(7'b0010001, 0, 2, 9, 4);
    tab_a[18] = mk(7'b0001101, 5, 3, 10, 4);  tab_a[19] = mk(7'b0110001, 0, 4, 11, 4);
    tab_a[20] = mk(7'b0010001, 0, 4, 11, 4);  tab_a[21] = mk(7'b0010001, 0, 4, 11, 4);
    tab_a[22] = mk(7'b0001111, 6, 4, 11, 4);  tab_a[23] = mk(7'b0000000, 0, 4, 11, 4);
    tab_a[24] = mk(7'b0000000, 0, 4, 11, 4);

    tab_z[0]  = mk(7'b0000000, 0, 0, 0, 0);   tab_z[1]  = mk(7'b0110001, 0, 0, 0, 0);
    tab_z[2]  = mk(7'b0010001, 0, 0, 0, 0);   tab_z[3]  = mk(7'b0001001, 2, 0, 0, 0);
    tab_z[4]  = mk(7'b0110001, 0, 0, 0, 0);   tab_z[5]  = mk(7'b0010001, 0, 0, 0, 0);
    tab_z[6]  = mk(7'b0001001, 3, 0, 0, 0);   tab_z[7]  = mk(7'b0110001, 0, 0, 0, 0);
    tab_z[8]  = mk(7'b0010001, 0, 0, 0, 0);   tab_z[9]  = mk(7'b0001001, 4, 0, 0, 0);
    tab_z[10] = mk(7'b0000001, 0, 0, 0, 0);   tab_z[11] = mk(7'b0110001, 0, 0, 0, 0);
    tab_z[12] = mk(7'b0010001, 0, 0, 0, 0);   tab_z[13] = mk(7'b0010001, 0, 0, 0, 0);
    tab_z[14] = mk(7'b0001101, 5, 0, 0, 0);   tab_z[15] = mk(7'b0110001, 0, 0, 0, 0);
    tab_z[16] = mk(7'b0010001, 0, 0, 0, 0);   tab_z[17] = mk(7'b0010001, 0, 0, 0, 0);
    tab_z[18] = mk(7'b0001111, 6, 0, 0, 0);
    for (int k = 19; k < 25; k++) tab_z[k] = mk(7'b0000000, 0, 0, 0, 0);

    // Nominal run on both depths; row 10 re-pulses start while busy.
    do_reset(1'b1);
    dones = 0;
    for (int c = 0; c < 25; c++) begin
      next_cycle();
      start = tab_a[c].f[6];
      @(negedge clk);
      check_a(c, c);
      check("pulses_z", c, 64'({clr_z, en_z, wr_z, last_z, done_z, busy_z}), 64'(tab_z[c].f[5:0]));
      if (tab_z[c].f[3]) check("oaddr_z", c, 64'(oaddr_z), 64'(tab_z[c].oa));
      if (done_a) dones++;
    end
    check("done_count_a", 25, 64'(dones), 64'd1);

    // Stall held for cycles 4..6: everything after shifts by three.
    do_reset(1'b0);
    exp_q.delete();
    for (int k = 2; k <= 6; k++) exp_q.push_back(12'(k));
    for (int c = 0; c < 29; c++) begin
      next_cycle();
      start = (c == 0);
      stall_a = (c >= 4 && c <= 6);
      @(negedge clk);
      check("wr_stall", c, 64'(wr_a), 64'(c == 8 || c == 11 || c == 14 || c == 21 || c == 25));
      check("done_stall", c, 64'(done_a), 64'(c == 25));
      check("busy_stall", c, 64'(busy_a), 64'(c >= 1 && c <= 25));
      if (c >= 4 && c <= 6) check("quiet_stall", c, 64'({clr_a, en_a}), 64'd0);
      if (c >= 4 && c <= 7) check("hold_stall", c, 64'({nrn_a, w_a, b_a}), 64'({12'd0, 16'd2, 8'd1}));
      if (wr_a) begin
        if (exp_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL extra_write cycle %0d: got write to %0d expected none", c, oaddr_a);
        end else begin
          check("oaddr_stall", c, 64'(oaddr_a), 64'(exp_q.pop_front()));
        end
      end
    end
    stall_a = 1'b0;
    check("stall_q_left", 29, 64'(exp_q.size()), 64'd0);

    // Reset during cycles 7..8 aborts the run; restart at 12 replays the nominal table.
    do_reset(1'b0);
    dones = 0;
    for (int c = 0; c < 37; c++) begin
      next_cycle();
      if (c == 7) rst_a = 1'b0;
      if (c == 9) rst_a = 1'b1;
      if (c >= 12) start = tab_a[c-12].f[6];
      else start = (c == 0);
      @(negedge clk);
      if (done_a) dones++;
      if (c < 7) check_a(c, c);
      else if (c < 12) check_quiet("abort_quiet", c);
      else check_a(c, c - 12);
    end
    check("done_count_c", 37, 64'(dones), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
